// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird core: data width, peripheral access types
// and the address decoder used by the bus crossbar.
package ladybird_config;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DISTRIBUTED_RAM = 2'd0,
        BLOCK_RAM       = 2'd1,
        DYNAMIC_RAM     = 2'd2,
        UART            = 2'd3
    } access_t;

    // Only the top nibble selects the target; anything unmapped lands in DRAM.
    function automatic access_t ladybird_xbar_decode(input logic [XLEN-1:0] addr);
        case (addr[XLEN-1:XLEN-4])
            4'hF:    return UART;
            4'h8:    return DISTRIBUTED_RAM;
            4'h9:    return BLOCK_RAM;
            default: return DYNAMIC_RAM;
        endcase
    endfunction

endpackage

// File: rtl/ladybird_crossbar_rr_route_fifo.sv
// Small FIFO holding, per peripheral, the index of the core owed each pending response.
module ladybird_xbar_route_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // The extra pointer bit tells a wrapped (full) FIFO apart from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ladybird_crossbar_rr.sv
// N-core x M-peripheral crossbar: per-peripheral round-robin arbitration with
// route FIFOs steering in-order responses back to the requesting core.
module ladybird_crossbar_rr
    import ladybird_config::*;
#(
    parameter int N_CORE          = 2,
    parameter int N_PERIPHERAL    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 arst,
    input  logic [N_CORE-1:0]                    core_req,
    input  logic [N_CORE-1:0][XLEN-1:0]          core_addr,
    input  logic [N_CORE-1:0][XLEN/8-1:0]        core_wstrb,
    input  logic [N_CORE-1:0][XLEN-1:0]          core_wdata,
    output logic [N_CORE-1:0]                    core_gnt,
    output logic [N_CORE-1:0][XLEN-1:0]          core_rdata,
    output logic [N_CORE-1:0]                    core_data_gnt,
    output logic [N_PERIPHERAL-1:0]              periph_req,
    output logic [N_PERIPHERAL-1:0][XLEN-1:0]    periph_addr,
    output logic [N_PERIPHERAL-1:0][XLEN/8-1:0]  periph_wstrb,
    output logic [N_PERIPHERAL-1:0][XLEN-1:0]    periph_wdata,
    input  logic [N_PERIPHERAL-1:0]              periph_gnt,
    input  logic [N_PERIPHERAL-1:0][XLEN-1:0]    periph_rdata,
    input  logic [N_PERIPHERAL-1:0]              periph_data_gnt,
    output logic                                 err_orphan
);

    localparam int CW = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam int PW = (N_PERIPHERAL > 1) ? $clog2(N_PERIPHERAL) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [PW-1:0]           target        [N_CORE];
    logic [OW-1:0]           outstanding_q [N_CORE];
    logic [PW-1:0]           last_target_q [N_CORE];
    logic [CW-1:0]           winner        [N_PERIPHERAL];
    logic [CW-1:0]           fifo_head     [N_PERIPHERAL];
    logic [N_PERIPHERAL-1:0] found, accept, pop, fifo_full, fifo_empty;
    logic                    err_orphan_q, err_orphan_d;

    for (genvar c = 0; c < N_CORE; c++) begin : g_decode
        access_t dec;
        always_comb begin
            dec = ladybird_xbar_decode(core_addr[c]);
            if (int'(dec) >= N_PERIPHERAL) target[c] = PW'(DYNAMIC_RAM);
            else                           target[c] = PW'(dec);
        end
    end

    for (genvar p = 0; p < N_PERIPHERAL; p++) begin : g_arb
        logic [CW-1:0]     rr_ptr_q, rr_ptr_d, win_l;
        logic [N_CORE-1:0] elig;
        logic              found_l;
        int                idx;

        // A core with pending responses may only keep talking to the same peripheral.
        always_comb begin
            for (int c = 0; c < N_CORE; c++) begin
                elig[c] = core_req[c] && (target[c] == PW'(p))
                       && (outstanding_q[c] < OW'(MAX_OUTSTANDING))
                       && ((outstanding_q[c] == '0) || (last_target_q[c] == PW'(p)))
                       && !fifo_full[p];
            end
        end

        always_comb begin
            found_l = 1'b0;
            win_l   = '0;
            idx     = 0;
            for (int k = 0; k < N_CORE; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_CORE;
                if (!found_l && elig[idx]) begin
                    found_l = 1'b1;
                    win_l   = CW'(idx);
                end
            end
        end

        assign found[p]        = found_l;
        assign winner[p]       = win_l;
        assign periph_req[p]   = found_l & ~arst;
        assign accept[p]       = periph_req[p] & periph_gnt[p];
        assign pop[p]          = periph_data_gnt[p] & ~fifo_empty[p] & ~arst;
        assign periph_addr[p]  = core_addr[win_l];
        assign periph_wstrb[p] = core_wstrb[win_l];
        assign periph_wdata[p] = core_wdata[win_l];

        always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (accept[p]) rr_ptr_d = CW'((int'(win_l) + 1) % N_CORE);
        end

        always_ff @(posedge clk or posedge arst) begin
            if (arst) rr_ptr_q <= '0;
            else      rr_ptr_q <= rr_ptr_d;
        end

        ladybird_xbar_route_fifo #(
            .DEPTH (MAX_OUTSTANDING),
            .WIDTH (CW)
        ) u_route_fifo (
            .clk       (clk),
            .arst      (arst),
            .push      (accept[p]),
            .push_data (win_l),
            .pop       (pop[p]),
            .head      (fifo_head[p]),
            .empty     (fifo_empty[p]),
            .full      (fifo_full[p])
        );
    end

    always_comb begin
        core_gnt      = '0;
        core_data_gnt = '0;
        core_rdata    = '0;
        for (int p = 0; p < N_PERIPHERAL; p++) begin
            if (accept[p]) core_gnt[winner[p]] = 1'b1;
            if (pop[p]) begin
                core_data_gnt[fifo_head[p]] = 1'b1;
                core_rdata[fifo_head[p]]    = periph_rdata[p];
            end
        end
    end

    for (genvar c = 0; c < N_CORE; c++) begin : g_core
        logic [OW-1:0] outstanding_d;
        logic [PW-1:0] last_target_d;

        always_comb begin
            last_target_d = last_target_q[c];
            for (int p = 0; p < N_PERIPHERAL; p++) begin
                if (accept[p] && (winner[p] == CW'(c))) last_target_d = PW'(p);
            end
            case ({core_gnt[c], core_data_gnt[c]})
                2'b10:   outstanding_d = outstanding_q[c] + OW'(1);
                2'b01:   outstanding_d = outstanding_q[c] - OW'(1);
                default: outstanding_d = outstanding_q[c];
            endcase
        end

        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                outstanding_q[c] <= '0;
                last_target_q[c] <= '0;
            end else begin
                outstanding_q[c] <= outstanding_d;
                last_target_q[c] <= last_target_d;
            end
        end
    end

    assign err_orphan_d = err_orphan_q | (|(periph_data_gnt & fifo_empty));
    assign err_orphan   = err_orphan_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) err_orphan_q <= 1'b0;
        else      err_orphan_q <= err_orphan_d;
    end

endmodule

// File: tb/tb_ladybird_crossbar_rr.sv
// Self-checking bench for ladybird_crossbar_rr: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ladybird_crossbar_rr;
    import ladybird_config::*;

    localparam int C    = 2;
    localparam int P    = 4;
    localparam int MAXO = 4;

    logic                      clk = 1'b0;
    logic                      arst;
    logic [C-1:0]              core_req;
    logic [C-1:0][XLEN-1:0]    core_addr, core_wdata, core_rdata;
    logic [C-1:0][XLEN/8-1:0]  core_wstrb;
    logic [C-1:0]              core_gnt, core_data_gnt;
    logic [P-1:0]              periph_req, periph_gnt, periph_data_gnt;
    logic [P-1:0][XLEN-1:0]    periph_addr, periph_wdata, periph_rdata;
    logic [P-1:0][XLEN/8-1:0]  periph_wstrb;
    logic                      err_orphan;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one queue of owed cores per peripheral.
    int m_q [P][$];
    int m_out  [C];
    int m_last [C];
    int m_rr   [P];
    bit m_orphan;

    logic [P-1:0]           e_preq;
    int                     e_win [P];
    logic [C-1:0]           e_gnt, e_dgnt, granted_prev;
    logic [C-1:0][XLEN-1:0] e_rdata;

    ladybird_crossbar_rr #(
        .N_CORE          (C),
        .N_PERIPHERAL    (P),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .core_req        (core_req),
        .core_addr       (core_addr),
        .core_wstrb      (core_wstrb),
        .core_wdata      (core_wdata),
        .core_gnt        (core_gnt),
        .core_rdata      (core_rdata),
        .core_data_gnt   (core_data_gnt),
        .periph_req      (periph_req),
        .periph_addr     (periph_addr),
        .periph_wstrb    (periph_wstrb),
        .periph_wdata    (periph_wdata),
        .periph_gnt      (periph_gnt),
        .periph_rdata    (periph_rdata),
        .periph_data_gnt (periph_data_gnt),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    function automatic int decodeModel(input logic [31:0] a);
        if (a[31:28] == 4'hF) return 3;
        if (a[31:28] == 4'h8) return 0;
        if (a[31:28] == 4'h9) return 1;
        return 2;
    endfunction

    task automatic modelReset();
        for (int p = 0; p < P; p++) begin
            m_q[p].delete();
            m_rr[p] = 0;
        end
        for (int c = 0; c < C; c++) begin
            m_out[c]  = 0;
            m_last[c] = 0;
        end
        m_orphan = 1'b0;
    endtask

    task automatic modelEval();
        int tgt [C];
        int c, h;
        if (arst) modelReset();
        e_preq  = '0;
        e_gnt   = '0;
        e_dgnt  = '0;
        e_rdata = '0;
        for (int i = 0; i < C; i++) tgt[i] = decodeModel(core_addr[i]);
        for (int p = 0; p < P; p++) begin
            e_win[p] = -1;
            if (!arst) begin
                for (int k = 0; k < C; k++) begin
                    c = (m_rr[p] + k) % C;
                    if (e_win[p] < 0 && core_req[c] && tgt[c] == p && m_out[c] < MAXO
                        && (m_out[c] == 0 || m_last[c] == p) && m_q[p].size() < MAXO)
                        e_win[p] = c;
                end
            end
            e_preq[p] = (e_win[p] >= 0);
            if (e_preq[p] && periph_gnt[p]) e_gnt[e_win[p]] = 1'b1;
            if (!arst && periph_data_gnt[p] && m_q[p].size() > 0) begin
                h          = m_q[p][0];
                e_dgnt[h]  = 1'b1;
                e_rdata[h] = periph_rdata[p];
            end
        end
    endtask

    task automatic modelCommit();
        int h, c;
        if (arst) return;
        for (int p = 0; p < P; p++) begin
            if (periph_data_gnt[p]) begin
                if (m_q[p].size() > 0) begin
                    h = m_q[p].pop_front();
                    m_out[h]--;
                end else begin
                    m_orphan = 1'b1;
                end
            end
        end
        for (int p = 0; p < P; p++) begin
            if (e_preq[p] && periph_gnt[p]) begin
                c = e_win[p];
                m_q[p].push_back(c);
                m_out[c]++;
                m_last[c] = p;
                m_rr[p]   = (c + 1) % C;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle the inputs driven at the falling edge, then compare every output.
    task automatic applyStimulus(input string name);
        #1;
        modelEval();
        checkOutput({name, "/periph_req"},    64'(periph_req),    64'(e_preq));
        checkOutput({name, "/core_gnt"},      64'(core_gnt),      64'(e_gnt));
        checkOutput({name, "/core_data_gnt"}, 64'(core_data_gnt), 64'(e_dgnt));
        checkOutput({name, "/core_rdata"},    64'(core_rdata),    64'(e_rdata));
        checkOutput({name, "/err_orphan"},    64'(err_orphan),    64'(m_orphan));
        for (int p = 0; p < P; p++) begin
            if (e_preq[p]) begin
                checkOutput($sformatf("%s/periph_addr%0d", name, p),
                            64'(periph_addr[p]), 64'(core_addr[e_win[p]]));
                checkOutput($sformatf("%s/periph_wdata%0d", name, p),
                            64'(periph_wdata[p]), 64'(core_wdata[e_win[p]]));
                checkOutput($sformatf("%s/periph_wstrb%0d", name, p),
                            64'(periph_wstrb[p]), 64'(core_wstrb[e_win[p]]));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelCommit();
        granted_prev = e_gnt;
        @(negedge clk);
    endtask

    task automatic tick(input string name);
        applyStimulus(name);
        advance();
    endtask

    task automatic idleInputs();
        core_req        = '0;
        core_addr       = '0;
        core_wstrb      = '0;
        core_wdata      = '0;
        periph_gnt      = '0;
        periph_data_gnt = '0;
        periph_rdata    = '0;
    endtask

    task automatic doReset();
        idleInputs();
        core_req        = 2'b11;
        core_addr[0]    = 32'hF000_0000;
        core_addr[1]    = 32'h9000_0000;
        periph_gnt      = '1;
        periph_data_gnt = '1;
        arst            = 1'b1;
        applyStimulus("reset");
        checkOutput("reset/req_forced", 64'(periph_req), 64'h0);
        checkOutput("reset/orphan_clr", 64'(err_orphan), 64'h0);
        advance();
        arst = 1'b0;
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] nib [4];
        nib[0] = 4'h8; nib[1] = 4'h9; nib[2] = 4'hF; nib[3] = 4'h2;
        granted_prev = '0;
        arst = 1'b1;
        idleInputs();
        modelReset();
        @(negedge clk);
        doReset();

        // Two cores to two different peripherals in the same cycle.
        core_req     = 2'b11;
        core_addr[0] = 32'hF000_0000;
        core_addr[1] = 32'h9000_0010;
        periph_gnt   = 4'b1111;
        applyStimulus("parallel");
        checkOutput("parallel/both_gnt", 64'(core_gnt), 64'h3);
        advance();
        idleInputs();
        periph_data_gnt = 4'b1010;
        periph_rdata[3] = 32'hAA;
        periph_rdata[1] = 32'hBB;
        applyStimulus("parallel_rsp");
        checkOutput("parallel_rsp/dgnt",   64'(core_data_gnt), 64'h3);
        checkOutput("parallel_rsp/rdata0", 64'(core_rdata[0]), 64'hAA);
        checkOutput("parallel_rsp/rdata1", 64'(core_rdata[1]), 64'hBB);
        advance();

        // Round-robin alternation on BRAM.
        doReset();
        core_req     = 2'b11;
        core_addr[0] = 32'h9000_0000;
        core_addr[1] = 32'h9000_0000;
        periph_gnt   = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rr");
            checkOutput($sformatf("rr/turn%0d", i), 64'(core_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
            advance();
        end
        idleInputs();
        periph_data_gnt = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            periph_rdata[1] = 32'h100 + i;
            tick("rr_drain");
        end

        // Switching peripheral waits for all pending responses.
        doReset();
        core_req      = 2'b01;
        core_addr[0]  = 32'h8000_0000;
        core_wstrb[0] = 4'hF;
        core_wdata[0] = 32'hDEAD_BEEF;
        periph_gnt    = 4'b1001;
        tick("block_wr");
        core_wstrb[0] = 4'h0;
        tick("block_rd");
        core_addr[0] = 32'hF000_0000;
        applyStimulus("block_wait");
        checkOutput("block_wait/gnt", 64'(core_gnt), 64'h0);
        advance();
        periph_data_gnt = 4'b0001;
        periph_rdata[0] = 32'h1234;
        for (int i = 0; i < 2; i++) begin
            applyStimulus("block_rsp");
            checkOutput($sformatf("block_rsp/gnt%0d", i), 64'(core_gnt), 64'h0);
            advance();
        end
        periph_data_gnt = '0;
        applyStimulus("block_release");
        checkOutput("block_release/gnt", 64'(core_gnt), 64'h1);
        advance();

        // Outstanding limit.
        doReset();
        core_req     = 2'b01;
        core_addr[0] = 32'h9000_0040;
        periph_gnt   = 4'b0010;
        for (int i = 0; i < MAXO; i++) begin
            applyStimulus("limit");
            checkOutput($sformatf("limit/gnt%0d", i), 64'(core_gnt), 64'h1);
            advance();
        end
        applyStimulus("limit_full");
        checkOutput("limit_full/gnt", 64'(core_gnt), 64'h0);
        advance();
        periph_data_gnt = 4'b0010;
        periph_rdata[1] = 32'h55;
        tick("limit_pop");
        periph_data_gnt = '0;
        applyStimulus("limit_reopen");
        checkOutput("limit_reopen/gnt", 64'(core_gnt), 64'h1);
        advance();

        // Orphan response.
        doReset();
        periph_data_gnt = 4'b0100;
        applyStimulus("orphan");
        checkOutput("orphan/no_dgnt", 64'(core_data_gnt), 64'h0);
        advance();
        periph_data_gnt = '0;
        applyStimulus("orphan_sticky");
        checkOutput("orphan_sticky/err", 64'(err_orphan), 64'h1);
        advance();
        arst = 1'b1;
        applyStimulus("orphan_clear");
        checkOutput("orphan_clear/err", 64'(err_orphan), 64'h0);
        advance();
        arst = 1'b0;

        // Reset with responses still owed.
        doReset();
        core_req     = 2'b01;
        core_addr[0] = 32'h8000_0000;
        periph_gnt   = 4'b1001;
        for (int i = 0; i < 3; i++) tick("mid_issue");
        periph_data_gnt = 4'b0001;
        arst = 1'b1;
        applyStimulus("mid_reset");
        checkOutput("mid_reset/req",   64'(periph_req),    64'h0);
        checkOutput("mid_reset/gnt",   64'(core_gnt),      64'h0);
        checkOutput("mid_reset/dgnt",  64'(core_data_gnt), 64'h0);
        checkOutput("mid_reset/rdata", 64'(core_rdata),    64'h0);
        advance();
        arst            = 1'b0;
        periph_data_gnt = '0;
        core_addr[0]    = 32'hF000_0000;
        applyStimulus("mid_switch");
        checkOutput("mid_switch/gnt", 64'(core_gnt), 64'h1);
        advance();

        // Randomized traffic with requests held until granted.
        doReset();
        granted_prev = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < C; c++) begin
                if (!core_req[c] || granted_prev[c]) begin
                    core_req[c]   = ($urandom % 3) != 0;
                    core_addr[c]  = {nib[$urandom % 4], 28'($urandom)};
                    core_wstrb[c] = 4'($urandom);
                    core_wdata[c] = $urandom;
                end
            end
            periph_gnt = 4'($urandom);
            for (int p = 0; p < P; p++) begin
                periph_rdata[p] = $urandom;
                if (m_q[p].size() > 0) periph_data_gnt[p] = ($urandom % 2) == 1;
                else                   periph_data_gnt[p] = ($urandom % 16) == 0;
            end
            arst = (i % 97 == 50);
            tick("rand");
        end
        arst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ladybird_crossbar_rr.md
# ladybird_crossbar_rr

Parametrised N-core × M-peripheral bus crossbar between the core bus masters (D-bus, I-bus, future DMA) and the peripherals (distributed RAM, block RAM, DRAM, UART). Any core reaches any peripheral through address decoding. Each peripheral has its own round-robin arbiter. A per-peripheral route FIFO steers each in-order response back to the core that issued the request. Per-core outstanding tracking keeps responses in order across peripherals.

## Interface
Parameters:
- N_CORE, default 2: number of core-side masters (index 0 = D-bus, 1 = I-bus).
- N_PERIPHERAL, default 4: number of peripheral-side slaves; index equals access type from the decoder.
- MAX_OUTSTANDING, default 4: route FIFO depth per peripheral, and per-core outstanding limit; power of two, ≥2.

Ports (XLEN from ladybird_config; C = N_CORE, P = N_PERIPHERAL):
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- core_req  in  [C]  request valid; held until core_gnt.
- core_addr  in  [C][XLEN]  byte address.
- core_wstrb  in  [C][XLEN/8]  byte write strobes; zero means read.
- core_wdata  in  [C][XLEN]  write data.
- core_gnt  out  [C]  request accepted this cycle.
- core_rdata  out  [C][XLEN]  response data; valid with core_data_gnt.
- core_data_gnt  out  [C]  one-cycle response pulse.
- periph_req  out  [P]  request to peripheral.
- periph_addr / periph_wstrb / periph_wdata  out  [P][XLEN] / [P][XLEN/8] / [P][XLEN]  winner's fields, passed through.
- periph_gnt  in  [P]  peripheral accepts.
- periph_rdata  in  [P][XLEN]  response data.
- periph_data_gnt  in  [P]  response pulse; one per accepted request, in acceptance order.
- err_orphan  out  1  sticky; set when a periph_data_gnt arrives while that peripheral's route FIFO is empty.

## Operation
- Decode: addr[31:28] = F → UART(3); 8 → DISTRIBUTED_RAM(0); 9 → BLOCK_RAM(1); all other values → DYNAMIC_RAM(2). Indices ≥ P fold to DYNAMIC_RAM.
- Eligibility: core c is eligible for peripheral p when all of these hold:
  - core_req[c]=1 and decode(core_addr[c])=p.
  - outstanding[c] < MAX_OUTSTANDING.
  - outstanding[c]=0 or last_target[c]=p. A core never has responses pending from two peripherals.
  - route FIFO p is not full.
- Arbitration per peripheral is round-robin. rr_ptr[p] names the highest-priority core, and the search runs rr_ptr[p], rr_ptr[p]+1, … modulo C.
  - periph_req[p] = any eligible core. periph_* fields carry the winner's values.
  - core_gnt[c] = periph_gnt[p] AND c is the winner of p.
- On an accepted transfer (periph_req & periph_gnt):
  - push c into FIFO p.
  - outstanding[c]++ and last_target[c] ← p.
  - rr_ptr[p] ← c+1 mod C.
  - rr_ptr[p] is unchanged when there is no transfer.
- On periph_data_gnt[p] with FIFO p non-empty:
  - pop head h.
  - core_data_gnt[h]=1 and core_rdata[h]=periph_rdata[p].
  - outstanding[h]--.
- A single core receives at most one response per cycle, because only one peripheral can hold its outstanding responses.
- core_rdata is 0 when core_data_gnt is 0.
- Simultaneous push and pop on the same FIFO: both take effect. Simultaneous increment and decrement of outstanding[c]: the value is unchanged.
- A full FIFO masks eligibility even if a pop happens in the same cycle.
- An orphan periph_data_gnt is dropped and sets err_orphan.

## Timing
- Request path is combinational, zero cycles: core_req → periph_req, and periph_gnt → core_gnt, in the same cycle.
- Response path is combinational, zero cycles: periph_data_gnt → core_data_gnt.
- State updates on the rising clk edge: FIFOs, outstanding counters, last_target, rr_ptr, err_orphan.
- Reset values:
  - FIFOs empty; outstanding 0; last_target 0; rr_ptr 0; err_orphan 0.
  - While arst=1, periph_req, core_gnt and core_data_gnt are forced 0, and core_rdata is 0.
- Reset mid-transaction discards all tracked responses. Peripherals share the same reset.

## Structure
- ladybird_config gains:
  - access_t (2-bit enum: DISTRIBUTED_RAM=0, BLOCK_RAM=1, DYNAMIC_RAM=2, UART=3).
  - function ladybird_xbar_decode(addr) returning access_t.
- One sub-module, ladybird_xbar_route_fifo:
  - parameters DEPTH and WIDTH = $clog2(N_CORE) (minimum 1).
  - ports: push, push_data, pop, head, empty, full; async active-high reset.
  - instantiated once per peripheral.
- Round-robin arbiters, outstanding counters ($clog2(MAX_OUTSTANDING+1) bits) and decode are generate loops in the top.

## Test plan
- Core0 reads 0xF000_0000 while core1 reads 0x9000_0010 in the same cycle, with both peripherals granting immediately → both core_gnt=1 in that cycle. UART's data_gnt with 0xAA reaches core0 only; BRAM's reaches core1 only.
- Both cores request 0x9000_0000 continuously with periph_gnt held 1 → grants alternate 0,1,0,1. After reset, the first grant goes to core0.
- Core0 issues a write then a read to 0x8000_0000 (data_gnt not yet returned), then requests 0xF000_0000 → the UART request stays blocked until both responses return, then is granted the next cycle.
- MAX_OUTSTANDING=4, core0 issues 4 BRAM reads with no responses → the fifth request sees core_gnt=0. One periph_data_gnt arrives → the fifth is granted the following cycle.
- periph_data_gnt[2] pulses with route FIFO 2 empty → no core_data_gnt and err_orphan=1 from the next edge onward. arst then clears it to 0.
- arst asserted with 3 outstanding responses → all outputs drop immediately. After release, the same core switches peripheral without blocking.
